// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage and imem.
//   iREN     fetch-side read request
//   imemaddr fetch address (the PC)
//   ihit     memory returns iload this cycle
//   iload    instruction word for imemaddr
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] iload;

    modport master (output iREN, output imemaddr, input ihit, input iload);
    modport slave  (input iREN, input imemaddr, output ihit, output iload);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, issues instruction reads and holds the IF/ID latch.
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   imem          instruction-memory bus (iREN, imemaddr, ihit, iload)
//   stall         hazard unit: hold PC and IF/ID
//   flush         hazard unit: replace IF/ID with a bubble
//   dcEN          hazard unit: IF/ID update enable
//   redirect      branch/jump resolved downstream, target in redirect_pc
//   halt_in       a halt instruction has committed downstream
//   instr_id, npc_id, valid_id   IF/ID latch contents
//   rs_id, rt_id  register fields of instr_id (combinational)
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic                 CLK,
    input  logic                 RST,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 dcEN,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 halt_in,
    output logic [31:0]          instr_id,
    output logic [31:0]          npc_id,
    output logic                 valid_id,
    output logic [4:0]           rs_id,
    output logic [4:0]           rt_id
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state, nextState;
    logic [31:0] pc, nextPc;
    logic [31:0] nextInstr, nextNpc;
    logic        nextValid;
    logic [31:0] pcPlus4;

    assign pcPlus4 = pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            pc       <= PC_INIT;
            instr_id <= '0;
            npc_id   <= '0;
            valid_id <= 1'b0;
        end else begin
            state    <= nextState;
            pc       <= nextPc;
            instr_id <= nextInstr;
            npc_id   <= nextNpc;
            valid_id <= nextValid;
        end
    end

    // Priority chain: committed halt, halted, redirect, flush, stall/!dcEN,
    // then normal fetch. Defaults hold everything so the stall branch is empty.
    always_comb begin
        nextState = state;
        nextPc    = pc;
        nextInstr = instr_id;
        nextNpc   = npc_id;
        nextValid = valid_id;
        if (halt_in) begin
            nextState = HALTED;
            nextInstr = '0;
            nextNpc   = '0;
            nextValid = 1'b0;
        end else if (state == HALTED) begin
            nextInstr = '0;
            nextNpc   = '0;
            nextValid = 1'b0;
        end else if (redirect) begin
            nextState = RUN;
            nextPc    = redirect_pc;
            nextInstr = '0;
            nextNpc   = '0;
            nextValid = 1'b0;
        end else if (flush) begin
            nextInstr = '0;
            nextNpc   = '0;
            nextValid = 1'b0;
        end else if (stall || !dcEN) begin
            // hold: the fetch at this PC is repeated once released
        end else if (state == RUN && imem.ihit) begin
            nextPc    = pcPlus4;
            nextInstr = imem.iload;
            nextNpc   = pcPlus4;
            nextValid = 1'b1;
            if (imem.iload[31:26] == HALT_OP) begin
                nextState = DRAIN;
            end
        end else begin
            nextInstr = '0;
            nextNpc   = '0;
            nextValid = 1'b0;
        end
    end

    assign imem.iREN     = (state == RUN);
    assign imem.imemaddr = pc;
    assign rs_id         = instr_id[25:21];
    assign rt_id         = instr_id[20:16];

endmodule
